// File: rtl/hbm_axi3_tester.sv
// hbm_axi3_tester
//   AXI3 master that exercises one HBM pseudo-channel. On an accepted start it
//   writes a counting pattern over num_bursts 16-beat INCR bursts starting at
//   base_addr. It then reads the region back and counts data mismatches, bad
//   RLAST and error responses into a saturating counter.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   start, base_addr,          run request (honoured only while busy=0) and
//   num_bursts                 its parameters, sampled on acceptance
//   busy, done, error_count    run status
//   M_AXI_*                    AXI3 master (AW/W/B/AR/R), one burst in flight
module hbm_axi3_tester #(
  parameter int unsigned DW = 256,
  parameter int unsigned IW = 6,
  parameter int unsigned AW = 34
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [15:0]     num_bursts,
  output logic            busy,
  output logic            done,
  output logic [31:0]     error_count,
  output logic [AW-1:0]   M_AXI_AWADDR,
  output logic [3:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [IW-1:0]   M_AXI_AWID,
  output logic [1:0]      M_AXI_AWBURST,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WVALID,
  output logic            M_AXI_WLAST,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  output logic [AW-1:0]   M_AXI_ARADDR,
  output logic            M_AXI_ARVALID,
  output logic [IW-1:0]   M_AXI_ARID,
  output logic [3:0]      M_AXI_ARLEN,
  output logic [2:0]      M_AXI_ARSIZE,
  output logic [1:0]      M_AXI_ARBURST,
  input  logic            M_AXI_ARREADY,
  input  logic [DW-1:0]   M_AXI_RDATA,
  input  logic            M_AXI_RVALID,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic            M_AXI_RLAST,
  output logic            M_AXI_RREADY
);

  localparam int unsigned    WORDS      = DW / 32;
  localparam int unsigned    BEAT_BYTES = DW / 8;
  localparam logic [2:0]     SIZE       = 3'($clog2(BEAT_BYTES));
  localparam logic [AW-1:0]  BURST_STEP = AW'(16 * BEAT_BYTES);
  localparam logic [31:0]    WORDS32    = 32'(WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_W_ADDR, S_W_DATA, S_W_RESP, S_R_ADDR, S_R_DATA, S_DONE
  } state_t;

  state_t        state, state_d;
  logic [15:0]   burst_cnt;
  logic [3:0]    beat_cnt;
  logic [15:0]   nb_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   err_q;
  logic          busy_q, done_q;

  logic          start_ok, last_burst, beat_last;
  logic          aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic [DW-1:0] pattern;
  logic [31:0]   g32;
  logic [1:0]    err_inc;
  logic [32:0]   err_sum;

  assign start_ok   = start && !busy_q;
  assign last_burst = (burst_cnt == nb_q - 16'd1);
  assign beat_last  = (beat_cnt == 4'd15);

  assign aw_fire = (state == S_W_ADDR) && M_AXI_AWREADY;
  assign w_fire  = (state == S_W_DATA) && M_AXI_WREADY;
  assign b_fire  = (state == S_W_RESP) && M_AXI_BVALID;
  assign ar_fire = (state == S_R_ADDR) && M_AXI_ARREADY;
  assign r_fire  = (state == S_R_DATA) && M_AXI_RVALID;

  // Counting pattern for the current global beat; shared by the write and
  // read phases since only one of them is ever active.
  always_comb begin
    pattern = '0;
    g32     = 32'({burst_cnt, beat_cnt});
    for (int unsigned j = 0; j < WORDS; j++) begin
      pattern[32*j +: 32] = g32 * WORDS32 + 32'(j);
    end
  end

  // Up to three independent error events can land on one read beat.
  always_comb begin
    err_inc = '0;
    if (b_fire && (M_AXI_BRESP != 2'b00)) begin
      err_inc = 2'd1;
    end
    if (r_fire) begin
      err_inc = {1'b0, (M_AXI_RDATA != pattern)}
              + {1'b0, (M_AXI_RRESP != 2'b00)}
              + {1'b0, (M_AXI_RLAST != beat_last)};
    end
    err_sum = {1'b0, err_q} + 33'(err_inc);
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_d = (num_bursts == '0) ? S_DONE : S_W_ADDR;
      S_W_ADDR:       if (aw_fire) state_d = S_W_DATA;
      S_W_DATA:       if (w_fire && beat_last) state_d = S_W_RESP;
      S_W_RESP:       if (b_fire) state_d = last_burst ? S_R_ADDR : S_W_ADDR;
      S_R_ADDR:       if (ar_fire) state_d = S_R_DATA;
      S_R_DATA:       if (r_fire && beat_last) state_d = last_burst ? S_DONE : S_R_ADDR;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
      beat_cnt  <= '0;
      nb_q      <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        nb_q      <= num_bursts;
        base_q    <= base_addr;
        addr_q    <= base_addr;
        burst_cnt <= '0;
        beat_cnt  <= '0;
        err_q     <= '0;
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
      end else begin
        err_q <= err_sum[32] ? '1 : err_sum[31:0];
        if (w_fire) beat_cnt <= beat_cnt + 4'd1;
        if (b_fire) begin
          if (last_burst) begin
            burst_cnt <= '0;
            addr_q    <= base_q;
          end else begin
            burst_cnt <= burst_cnt + 16'd1;
            addr_q    <= addr_q + BURST_STEP;
          end
        end
        if (r_fire) begin
          beat_cnt <= beat_cnt + 4'd1;
          if (beat_last && !last_burst) begin
            burst_cnt <= burst_cnt + 16'd1;
            addr_q    <= addr_q + BURST_STEP;
          end
        end
        if (r_fire && beat_last && last_burst) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else if (state == S_DONE && busy_q) begin
          // Zero-burst run: status flips one edge after the start edge.
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  // All AXI outputs decode registered state only; payloads read as zero
  // whenever their VALID is low so an idle master drives all-zero.
  assign M_AXI_AWVALID = (state == S_W_ADDR);
  assign M_AXI_AWADDR  = M_AXI_AWVALID ? addr_q : '0;
  assign M_AXI_AWLEN   = M_AXI_AWVALID ? 4'd15 : '0;
  assign M_AXI_AWSIZE  = M_AXI_AWVALID ? SIZE : '0;
  assign M_AXI_AWBURST = M_AXI_AWVALID ? 2'b01 : '0;
  assign M_AXI_AWID    = '0;

  assign M_AXI_WVALID  = (state == S_W_DATA);
  assign M_AXI_WDATA   = M_AXI_WVALID ? pattern : '0;
  assign M_AXI_WSTRB   = M_AXI_WVALID ? '1 : '0;
  assign M_AXI_WLAST   = M_AXI_WVALID && beat_last;

  assign M_AXI_BREADY  = (state == S_W_RESP);

  assign M_AXI_ARVALID = (state == S_R_ADDR);
  assign M_AXI_ARADDR  = M_AXI_ARVALID ? addr_q : '0;
  assign M_AXI_ARLEN   = M_AXI_ARVALID ? 4'd15 : '0;
  assign M_AXI_ARSIZE  = M_AXI_ARVALID ? SIZE : '0;
  assign M_AXI_ARBURST = M_AXI_ARVALID ? 2'b01 : '0;
  assign M_AXI_ARID    = '0;

  assign M_AXI_RREADY  = (state == S_R_DATA);

  assign busy        = busy_q;
  assign done        = done_q;
  assign error_count = err_q;

endmodule
